// File: rtl/bcd_conv_sched.sv
// Four-channel round-robin scheduler sharing one 16-iteration double-dabble engine.
// Optional two's-complement operands with a sign flag: define BCD_SCHED_SIGN_EN.
module bcd_conv_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_i,
  input  logic [63:0] bin_i,
  output logic [3:0]  ack_o,
  output logic [19:0] bcd_o,
  output logic [1:0]  ch_o,
  output logic        valid_o,
  output logic        sign_o,
  output logic        busy_o
);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e      state_q;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  ch_q;
  logic [3:0]  cnt_q;
  logic [35:0] sr_q;
  logic [35:0] sr_adj;
  logic [35:0] sr_step;

  logic [3:0]  ack_q;
  logic [19:0] bcd_q;
  logic [1:0]  ch_out_q;
  logic        valid_q;

  logic        gnt_valid;
  logic [1:0]  gnt_ch;
  logic [1:0]  cand;
  logic [15:0] operand;
  logic [15:0] load_val;
  logic        grant;
  logic        done;

  // Offsets are scanned high to low so the smallest offset from rr_ptr_q wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr_q + 2'(i);
      if (req_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_ch    = cand;
      end
    end
  end

  assign operand = bin_i[{gnt_ch, 4'b0000} +: 16];
  assign grant   = (state_q == StIdle) && gnt_valid;
  assign done    = (state_q == StConv) && (cnt_q == 4'd15);

  // One double-dabble iteration: correct digits >= 5, then shift.
  always_comb begin
    sr_adj = sr_q;
    for (int d = 0; d < 5; d++) begin
      if (sr_q[16 + 4*d +: 4] >= 4'd5) begin
        sr_adj[16 + 4*d +: 4] = sr_q[16 + 4*d +: 4] + 4'd3;
      end
    end
    sr_step = sr_adj << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= 2'd0;
      ch_q     <= 2'd0;
      cnt_q    <= 4'd0;
      sr_q     <= 36'd0;
      ack_q    <= 4'd0;
      bcd_q    <= 20'd0;
      ch_out_q <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ack_q   <= 4'd0;
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            sr_q    <= {20'd0, load_val};
            cnt_q   <= 4'd0;
            ch_q    <= gnt_ch;
            state_q <= StConv;
          end
        end
        StConv: begin
          sr_q  <= sr_step;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            bcd_q    <= sr_step[35:16];
            ch_out_q <= ch_q;
            valid_q  <= 1'b1;
            ack_q    <= 4'b0001 << ch_q;
            rr_ptr_q <= ch_q + 2'd1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef BCD_SCHED_SIGN_EN
  logic neg_pend_q;
  logic sign_q;

  // Magnitude of -32768 is 16'h8000, which still fits the 16-bit load field.
  assign load_val = operand[15] ? (~operand + 16'd1) : operand;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_pend_q <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      if (grant) neg_pend_q <= operand[15];
      if (done)  sign_q     <= neg_pend_q;
    end
  end

  assign sign_o = sign_q;
`else
  assign load_val = operand;
  assign sign_o   = 1'b0;
`endif

  assign ack_o   = ack_q;
  assign bcd_o   = bcd_q;
  assign ch_o    = ch_out_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == StConv);

endmodule
